// File: rtl/cdf_top.sv
// -----------------------------------------------------------------------------
// cdf_top -- cumulative-distribution stage of the histogram-equalisation pipe.
//
// Walks the 256-bin histogram in scratch memory, four 32-bit bins per 128-bit
// word, and writes the running-sum CDF back to scratch memory with the same
// lane mapping (bin 4k+i in word k, bits [32i+31:32i]). It reports the first
// non-zero CDF value (cdf_min) and the final value (cdf_total) for the
// downstream divide/map stage.
//
// Each word takes two cycles. RD presents the read address, and ACC consumes
// the registered read data and writes the four CDF lanes.
//
// Ports:
//   clk              rising-edge clock
//   reset            asynchronous active-low reset
//   enable           start request, honoured only in IDLE or DONE
//   sc_mem_rd_data1  scratch read data, valid the cycle after the address
//   sc_mem_rd_addr1  scratch read address; holds its value outside RD
//   sc_mem_wt_addr   scratch write address (valid while sc_mem_wt_en)
//   sc_mem_wt_data   scratch write data    (valid while sc_mem_wt_en)
//   sc_mem_wt_en     scratch write enable, one cycle per CDF word
//   cdf_min          first non-zero CDF value in bin order
//   cdf_total        CDF value of bin 255 (pixel count)
//   cdf_done         level, high once the whole CDF has been written
//   busy             high while reading/accumulating (RD or ACC)
// -----------------------------------------------------------------------------
module cdf_top #(
    parameter logic [15:0] HIST_BASE = 16'd0,
    parameter logic [15:0] CDF_BASE  = 16'd64,
    parameter int          NUM_WORDS = 64,
    parameter int          CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [4*CNT_W-1:0]   sc_mem_rd_data1,
    output logic [15:0]          sc_mem_rd_addr1,
    output logic [15:0]          sc_mem_wt_addr,
    output logic [4*CNT_W-1:0]   sc_mem_wt_data,
    output logic                 sc_mem_wt_en,
    output logic [CNT_W-1:0]     cdf_min,
    output logic [CNT_W-1:0]     cdf_total,
    output logic                 cdf_done,
    output logic                 busy
);

    localparam int K_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(NUM_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_ACC,
        S_DONE
    } state_e;

    state_e             state_q,     state_d;
    logic [K_W-1:0]     k_q,         k_d;
    logic [CNT_W-1:0]   sum_q,       sum_d;
    logic               min_found_q, min_found_d;
    logic [CNT_W-1:0]   cdf_min_q,   cdf_min_d;
    logic [CNT_W-1:0]   cdf_total_q, cdf_total_d;
    logic [15:0]        rd_addr_q,   rd_addr_d;

    // Running sums of the four lanes of the current word (wrap modulo 2^CNT_W).
    logic [CNT_W-1:0]   c_lane [4];
    logic               lane_hit;
    logic [CNT_W-1:0]   lane_min;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            c_lane[i] = ((i == 0) ? sum_q : c_lane[(i == 0) ? 0 : i - 1])
                        + sc_mem_rd_data1[CNT_W*i +: CNT_W];
        end
    end

    // Scan from lane 3 down so the lowest non-zero lane wins.
    always_comb begin
        lane_hit = 1'b0;
        lane_min = '0;
        for (int i = 3; i >= 0; i--) begin
            if (c_lane[i] != '0) begin
                lane_hit = 1'b1;
                lane_min = c_lane[i];
            end
        end
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            k_q         <= '0;
            sum_q       <= '0;
            min_found_q <= 1'b0;
            cdf_min_q   <= '0;
            cdf_total_q <= '0;
            rd_addr_q   <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            sum_q       <= sum_d;
            min_found_q <= min_found_d;
            cdf_min_q   <= cdf_min_d;
            cdf_total_q <= cdf_total_d;
            rd_addr_q   <= rd_addr_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every signal gets its hold value first, so no path through the
    // case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        sum_d       = sum_q;
        min_found_d = min_found_q;
        cdf_min_d   = cdf_min_q;
        cdf_total_d = cdf_total_q;
        rd_addr_d   = rd_addr_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (enable) begin
                    state_d     = S_RD;
                    k_d         = '0;
                    sum_d       = '0;
                    min_found_d = 1'b0;
                    cdf_min_d   = '0;
                    cdf_total_d = '0;
                    // The address is loaded on entry so it is stable for the RD cycle.
                    rd_addr_d   = HIST_BASE;
                end
            end
            S_RD: begin
                state_d = S_ACC;
            end
            S_ACC: begin
                sum_d = c_lane[3];
                if (!min_found_q && lane_hit) begin
                    cdf_min_d   = lane_min;
                    min_found_d = 1'b1;
                end
                if (k_q == K_LAST) begin
                    cdf_total_d = c_lane[3];
                    state_d     = S_DONE;
                end else begin
                    k_d       = k_q + 1'b1;
                    rd_addr_d = HIST_BASE + 16'(k_q + 1'b1);
                    state_d   = S_RD;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Output logic
    // -------------------------------------------------------------------------
    always_comb begin
        sc_mem_wt_en   = 1'b0;
        sc_mem_wt_addr = '0;
        sc_mem_wt_data = '0;
        if (state_q == S_ACC) begin
            sc_mem_wt_en   = 1'b1;
            sc_mem_wt_addr = CDF_BASE + 16'(k_q);
            sc_mem_wt_data = {c_lane[3], c_lane[2], c_lane[1], c_lane[0]};
        end
    end

    assign sc_mem_rd_addr1 = rd_addr_q;
    assign cdf_min         = cdf_min_q;
    assign cdf_total       = cdf_total_q;
    assign cdf_done        = (state_q == S_DONE);
    assign busy            = (state_q == S_RD) || (state_q == S_ACC);

endmodule
